rce_parity_accumulator: RTL

- Upstream feeder for the final parity register stage of the parallel ring-circulant encoder.
- Consumes a codeword's message bits serially, one per accepted cycle, together with the matching M-bit generator row from the circulant ROM.
- Accumulates parity in a shift-register-adder-accumulator (rotate, then XOR).
- After K bits, presents the M-bit parity with a one-cycle load strobe: par_out drives the final register's data input, par_sel drives its select.

---
 rtl/rce_parity_accumulator.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rce_parity_accumulator.sv
// Serial parity accumulator for the ring-circulant encoder: folds one message
// bit per accepted cycle into an M-bit rotate-then-XOR accumulator and hands the
// result to the final parity register with a one-cycle load strobe.
// Optional build macro RCE_START_ERR_EN: adds a sticky err output and makes a
// start during accumulation an error instead of a restart.
module rce_parity_accumulator #(
  parameter int unsigned M  = 4,
  parameter int unsigned K  = 64,
  localparam int unsigned CW = $clog2(K)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         msg_valid,
  input  logic         msg_bit,
  input  logic [M-1:0] g_row,
`ifdef RCE_START_ERR_EN
  output logic         err,
`endif
  output logic         msg_ready,
  output logic         busy,
  output logic [M-1:0] par_out,
  output logic         par_sel,
  output logic         par_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           msg_ready_d, busy_d, par_sel_d, par_valid_d;
  logic           take;
  logic [M-1:0]   p_acc;
  logic           last_bit;

`ifdef RCE_START_ERR_EN
  logic err_q, err_d;
  assign err = err_q;
`endif

  // GF(2) accumulator step: rotate left by one, then add the row if the bit is set
  assign p_acc    = {p_q[M-2:0], p_q[M-1]} ^ (msg_bit ? g_row : '0);
  assign last_bit = (cnt_q == CW'(K - 1));
  assign par_out  = p_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
`ifdef RCE_START_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
          p_d     = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
`ifdef RCE_START_ERR_EN
        if (start) err_d = 1'b1;
        take = msg_valid;
`else
        if (start) begin
          p_d   = '0;
          cnt_d = '0;
        end else begin
          take = msg_valid;
        end
`endif
        if (take) begin
          p_d = p_acc;
          // Counter parks at K-1 on the final bit so it never wraps
          if (last_bit) state_d = DONE;
          else          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    msg_ready_d = (state_d == ACC);
    busy_d      = (state_d != IDLE);
    par_valid_d = (state_d == DONE);
    par_sel_d   = (state_d != DONE);
  end

  // State, accumulator and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      cnt_q     <= '0;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
      par_valid <= 1'b0;
      par_sel   <= 1'b1;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      msg_ready <= msg_ready_d;
      busy      <= busy_d;
      par_valid <= par_valid_d;
      par_sel   <= par_sel_d;
    end
  end

`ifdef RCE_START_ERR_EN
  // Sticky start-during-accumulation flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
`endif

endmodule
